// File: rtl/frame_generator_multilane.sv
// Multi-lane test frame generator: idle/start/data/terminate words per lane.
// Lengths come from fixed config or a per-lane 16-bit LFSR.
module frame_generator_multilane #(
  parameter int          N_LANES     = 4,
  parameter int          NB_DATA_RAW = 64,
  parameter int          NB_CTRL_RAW = 8,
  parameter int          NB_LEN      = 8,
  parameter logic [15:0] SEED_BASE   = 16'hACE1
) (
  input  logic                           i_clock,
  input  logic                           i_reset_n,
  input  logic                           i_enable,
  input  logic [1:0]                     i_mode,
  input  logic [NB_LEN-1:0]              i_fix_idle,
  input  logic [NB_LEN-1:0]              i_fix_data,
  input  logic [2:0]                     i_fix_term,
  input  logic [NB_LEN-1:0]              i_max_data,
  output logic [N_LANES*NB_DATA_RAW-1:0] o_tx_data,
  output logic [N_LANES*NB_CTRL_RAW-1:0] o_tx_ctrl,
  output logic [N_LANES-1:0]             o_sof,
  output logic [N_LANES-1:0]             o_eof
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_TERM
  } state_e;

  localparam logic [63:0] IDLE_W  = 64'h0707_0707_0707_0707;
  localparam logic [63:0] START_W = 64'hD555_5555_5555_55FB;

  logic              idle_only;
  logic              rnd_mode;
  logic [NB_LEN-1:0] max_clamp;
  logic [NB_LEN-1:0] fix_idle_c;
  logic [NB_LEN-1:0] fix_data_c;

  assign idle_only  = i_mode[1];
  assign rnd_mode   = (i_mode == 2'd1);
  assign max_clamp  = (i_max_data == '0) ? NB_LEN'(1) : i_max_data;
  assign fix_idle_c = (i_fix_idle == '0) ? NB_LEN'(1) : i_fix_idle;
  assign fix_data_c = (i_fix_data == '0) ? NB_LEN'(1) : i_fix_data;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    state_e            st_q, st_d;
    logic [NB_LEN-1:0] cnt_q, cnt_d;
    logic [NB_LEN-1:0] ndat_q, ndat_d;
    logic [2:0]        nterm_q, nterm_d;
    logic [7:0]        bcnt_q, bcnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [63:0]       dat_q, dat_d;
    logic [7:0]        ctl_q, ctl_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;

    logic [NB_LEN-1:0] r_idle, r_data;
    logic [NB_LEN-1:0] s_idle, s_data;
    logic [2:0]        s_term;
    logic [63:0]       pay_w, term_w;
    logic [7:0]        term_c;
    logic              smp;

    always_comb begin
      r_idle = NB_LEN'(lfsr_q[4:0]);
      r_data = NB_LEN'(lfsr_q[12:5]);
      if (r_idle == '0) r_idle = NB_LEN'(1);
      if (r_data == '0) r_data = NB_LEN'(1);
      if (r_data > max_clamp) r_data = max_clamp;
      s_idle = rnd_mode ? r_idle : fix_idle_c;
      s_data = rnd_mode ? r_data : fix_data_c;
      s_term = rnd_mode ? lfsr_q[15:13] : i_fix_term;
    end

    always_comb begin
      pay_w  = '0;
      term_w = '0;
      term_c = '0;
      for (int i = 0; i < 8; i++) begin
        pay_w[8*i +: 8] = bcnt_q + 8'(i);
        if (3'(i) < nterm_q) begin
          term_w[8*i +: 8] = bcnt_q + 8'(i);
          term_c[i]        = 1'b0;
        end else if (3'(i) == nterm_q) begin
          term_w[8*i +: 8] = 8'hFD;
          term_c[i]        = 1'b1;
        end else begin
          term_w[8*i +: 8] = 8'h07;
          term_c[i]        = 1'b1;
        end
      end
    end

    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      ndat_d  = ndat_q;
      nterm_d = nterm_q;
      bcnt_d  = bcnt_q;
      lfsr_d  = lfsr_q;
      dat_d   = dat_q;
      ctl_d   = ctl_q;
      sof_d   = sof_q;
      eof_d   = eof_q;
      smp     = 1'b0;
      if (i_enable) begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                  lfsr_q[15:1]};
        sof_d  = 1'b0;
        eof_d  = 1'b0;
        unique case (st_q)
          S_IDLE: begin
            if (cnt_q != '0) begin
              dat_d = IDLE_W;
              ctl_d = 8'hFF;
              cnt_d = cnt_q - NB_LEN'(1);
            end else if (idle_only) begin
              dat_d = IDLE_W;
              ctl_d = 8'hFF;
              smp   = 1'b1;
            end else begin
              dat_d = START_W;
              ctl_d = 8'h01;
              sof_d = 1'b1;
              st_d  = S_START;
            end
          end
          S_START: begin
            dat_d  = pay_w;
            ctl_d  = 8'h00;
            bcnt_d = bcnt_q + 8'd8;
            cnt_d  = ndat_q - NB_LEN'(1);
            st_d   = S_DATA;
          end
          S_DATA: begin
            if (cnt_q != '0) begin
              dat_d  = pay_w;
              ctl_d  = 8'h00;
              bcnt_d = bcnt_q + 8'd8;
              cnt_d  = cnt_q - NB_LEN'(1);
            end else begin
              dat_d  = term_w;
              ctl_d  = term_c;
              bcnt_d = bcnt_q + {5'd0, nterm_q};
              eof_d  = 1'b1;
              st_d   = S_TERM;
            end
          end
          S_TERM: begin
            dat_d = IDLE_W;
            ctl_d = 8'hFF;
            smp   = 1'b1;
            st_d  = S_IDLE;
          end
          default: st_d = S_IDLE;
        endcase
        if (smp) begin
          cnt_d   = s_idle - NB_LEN'(1);
          ndat_d  = s_data;
          nterm_d = s_term;
        end
      end
    end

    // Reset parks the lane as if a frame just ended, so the first
    // enabled edge samples lengths and emits the first idle word.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        st_q    <= S_TERM;
        cnt_q   <= '0;
        ndat_q  <= NB_LEN'(1);
        nterm_q <= '0;
        bcnt_q  <= '0;
        lfsr_q  <= SEED_BASE + 16'(k);
        dat_q   <= IDLE_W;
        ctl_q   <= 8'hFF;
        sof_q   <= 1'b0;
        eof_q   <= 1'b0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        ndat_q  <= ndat_d;
        nterm_q <= nterm_d;
        bcnt_q  <= bcnt_d;
        lfsr_q  <= lfsr_d;
        dat_q   <= dat_d;
        ctl_q   <= ctl_d;
        sof_q   <= sof_d;
        eof_q   <= eof_d;
      end
    end

    assign o_tx_data[k*NB_DATA_RAW +: NB_DATA_RAW] = dat_q;
    assign o_tx_ctrl[k*NB_CTRL_RAW +: NB_CTRL_RAW] = ctl_q;
    assign o_sof[k] = sof_q;
    assign o_eof[k] = eof_q;
  end

endmodule

// File: tb/tb_frame_generator_multilane.sv
// Bench for frame_generator_multilane: directed phases plus random-length
// traffic against a queue-based frame model.
module tb_frame_generator_multilane;

  localparam int NL = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [1:0]      mode;
  logic [7:0]      fix_idle, fix_data, max_data;
  logic [2:0]      fix_term;
  logic [NL*64-1:0] tx_data;
  logic [NL*8-1:0]  tx_ctrl;
  logic [NL-1:0]    sof, eof;

  frame_generator_multilane dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_enable   (en),
    .i_mode     (mode),
    .i_fix_idle (fix_idle),
    .i_fix_data (fix_data),
    .i_fix_term (fix_term),
    .i_max_data (max_data),
    .o_tx_data  (tx_data),
    .o_tx_ctrl  (tx_ctrl),
    .o_sof      (sof),
    .o_eof      (eof)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model tokens: 0 idle, 1 start, 2 data, 16+t terminate at byte t
  int          tq [NL][$];
  bit          need_idle [NL];
  int          pend_data [NL];
  int          pend_term [NL];
  logic [7:0]  bc [NL];
  logic [15:0] lf [NL];
  logic [63:0] exp_d [NL];
  logic [7:0]  exp_c [NL];
  logic        exp_s [NL];
  logic        exp_e [NL];
  int          frames0;

  task automatic chk64(string tag, logic [63:0] obs, logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NL; k++) begin
      tq[k].delete();
      need_idle[k] = 1'b1;
      pend_data[k] = 1;
      pend_term[k] = 0;
      bc[k] = 8'h00;
      lf[k] = 16'hACE1 + 16'(k);
      exp_d[k] = 64'h0707_0707_0707_0707;
      exp_c[k] = 8'hFF;
      exp_s[k] = 1'b0;
      exp_e[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NL; k++) begin
      int ni, nd, nt, mx, tok;
      if (tq[k].size() == 0) begin
        if (need_idle[k] || mode >= 2) begin
          if (mode == 1) begin
            ni = int'(lf[k]) % 32;
            nd = (int'(lf[k]) / 32) % 256;
            nt = int'(lf[k]) / 8192;
            mx = (max_data == 0) ? 1 : int'(max_data);
            if (nd < 1) nd = 1;
            if (nd > mx) nd = mx;
          end else begin
            ni = int'(fix_idle);
            nd = int'(fix_data);
            nt = int'(fix_term);
            if (nd < 1) nd = 1;
          end
          if (ni < 1) ni = 1;
          repeat (ni) tq[k].push_back(0);
          pend_data[k] = nd;
          pend_term[k] = nt;
          need_idle[k] = 1'b0;
        end else begin
          tq[k].push_back(1);
          repeat (pend_data[k]) tq[k].push_back(2);
          tq[k].push_back(16 + pend_term[k]);
          need_idle[k] = 1'b1;
        end
      end
      tok = tq[k].pop_front();
      exp_s[k] = (tok == 1);
      exp_e[k] = (tok >= 16);
      if (tok == 0) begin
        exp_d[k] = 64'h0707_0707_0707_0707;
        exp_c[k] = 8'hFF;
      end else if (tok == 1) begin
        exp_d[k] = 64'hD555_5555_5555_55FB;
        exp_c[k] = 8'h01;
      end else if (tok == 2) begin
        for (int i = 0; i < 8; i++) exp_d[k][8*i +: 8] = bc[k] + 8'(i);
        exp_c[k] = 8'h00;
        bc[k] = bc[k] + 8'd8;
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (i < tok - 16) begin
            exp_d[k][8*i +: 8] = bc[k] + 8'(i);
            exp_c[k][i] = 1'b0;
          end else begin
            exp_d[k][8*i +: 8] = (i == tok - 16) ? 8'hFD : 8'h07;
            exp_c[k][i] = 1'b1;
          end
        end
        bc[k] = bc[k] + 8'(tok - 16);
        if (k == 0) frames0++;
      end
      // taps 16,14,13,11: new bit enters at the top, shift right
      lf[k] = (lf[k] >> 1) |
              16'((lf[k][0] ^ lf[k][2] ^ lf[k][3] ^ lf[k][5]) << 15);
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < NL; k++) begin
      n_chk++;
      assert (tx_data[k*64 +: 64] === exp_d[k]) else begin
        n_fail++;
        $error("FAIL %s data lane%0d observed=%h expected=%h",
               tag, k, tx_data[k*64 +: 64], exp_d[k]);
      end
      n_chk++;
      assert (tx_ctrl[k*8 +: 8] === exp_c[k]) else begin
        n_fail++;
        $error("FAIL %s ctrl lane%0d observed=%h expected=%h",
               tag, k, tx_ctrl[k*8 +: 8], exp_c[k]);
      end
      n_chk++;
      assert ({sof[k], eof[k]} === {exp_s[k], exp_e[k]}) else begin
        n_fail++;
        $error("FAIL %s sof/eof lane%0d observed=%b%b expected=%b%b",
               tag, k, sof[k], eof[k], exp_s[k], exp_e[k]);
      end
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    #1;
    if (rst_n && en) model_edge();
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int dc [NL];
  int ic [NL];
  bit inf [NL];
  bit icv [NL];
  logic [63:0] h [NL];
  int cyc;
  bit found;

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0;
    fix_idle = 8'd2; fix_data = 8'd3; fix_term = 3'd5; max_data = 8'd4;
    frames0 = 0;
    model_reset();
    do_reset();

    // fixed 2/3/5
    en = 1'b1;
    for (int s = 1; s <= 21; s++) begin
      step("fixed235");
      if (s == 3) chk64("fixed_sof_l3", 64'(sof[3]), 64'd1);
      if (s == 7) begin
        chk64("fixed_term_l3", tx_data[3*64 +: 64], 64'h0707_FD1C_1B1A_1918);
        chk64("fixed_tctrl_l3", 64'(tx_ctrl[3*8 +: 8]), 64'hE0);
      end
      if (s == 14) chk64("fixed_eof2_l0", 64'(eof[0]), 64'd1);
    end

    // async reset mid-DATA
    do_reset();
    repeat (4) step("pre_async");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // zero lengths behave as 1
    fix_idle = 8'd0; fix_data = 8'd0; fix_term = 3'd0;
    for (int s = 1; s <= 12; s++) begin
      step("fixed000");
      if (s == 4 || s == 8) begin
        chk64("zero_term_l1", tx_data[1*64 +: 64], 64'h0707_0707_0707_07FD);
        chk64("zero_tctrl_l1", 64'(tx_ctrl[1*8 +: 8]), 64'hFF);
      end
    end

    // enable stall in DATA
    fix_idle = 8'd2; fix_data = 8'd3; fix_term = 3'd5;
    do_reset();
    en = 1'b1;
    repeat (4) step("stall_pre");
    en = 1'b0;
    repeat (2) step("stall_hold");
    chk64("stall_held_l0", tx_data[63:0], 64'h0706_0504_0302_0100);
    en = 1'b1;
    step("stall_resume");
    chk64("stall_next_l0", tx_data[63:0], 64'h0F0E_0D0C_0B0A_0908);
    repeat (10) step("stall_post");

    // idle-only switch mid-DATA, then back to fixed
    do_reset();
    repeat (4) step("m2_pre");
    mode = 2'd2;
    repeat (30) step("m2_idle");
    mode = 2'd0;
    found = 1'b0;
    for (int s = 0; s < 6 && !found; s++) begin
      step("m0_back");
      if (sof[0]) found = 1'b1;
    end
    chk64("m0_restart_sof", 64'(found), 64'd1);
    repeat (10) step("m0_post");

    // random lengths, random enable
    do_reset();
    mode = 2'd1; max_data = 8'd4;
    frames0 = 0;
    cyc = 0;
    for (int k = 0; k < NL; k++) begin
      dc[k] = 0; ic[k] = 0; inf[k] = 1'b0; icv[k] = 1'b0; h[k] = '0;
    end
    while (frames0 < 1000 && cyc < 60000) begin
      en = ($urandom_range(0, 9) != 0);
      step("random");
      cyc++;
      if (en) begin
        for (int k = 0; k < NL; k++) begin
          logic [7:0] c;
          c = tx_ctrl[k*8 +: 8];
          h[k] = {h[k][62:0], h[k][63]} ^ tx_data[k*64 +: 64];
          if (sof[k]) begin
            if (icv[k]) begin
              n_chk++;
              assert (ic[k] >= 1 && ic[k] <= 31) else begin
                n_fail++;
                $error("FAIL rnd_idle_len lane%0d observed=%0d expected=1..31",
                       k, ic[k]);
              end
            end
            inf[k] = 1'b1; dc[k] = 0;
          end else if (eof[k]) begin
            if (inf[k]) begin
              n_chk++;
              assert (dc[k] >= 1 && dc[k] <= 4) else begin
                n_fail++;
                $error("FAIL rnd_data_len lane%0d observed=%0d expected=1..4",
                       k, dc[k]);
              end
            end
            inf[k] = 1'b0; ic[k] = 0; icv[k] = 1'b1;
          end else if (c == 8'h00) begin
            dc[k]++;
          end else if (c == 8'hFF) begin
            ic[k]++;
          end
        end
      end
    end
    n_chk++;
    assert (frames0 >= 1000) else begin
      n_fail++;
      $error("FAIL rnd_timeout observed=%0d expected=1000 frames", frames0);
    end
    for (int k = 1; k < NL; k++) begin
      n_chk++;
      assert (h[k] !== h[0]) else begin
        n_fail++;
        $error("FAIL rnd_lanes_differ lane%0d observed=%h expected!=%h",
               k, h[k], h[0]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
